// File: rtl/bk_pulse_monitor.sv
// Breakdown-test feedback pulse monitor: measures high width and rise-to-rise
// period, qualifies them against limits and flags fault and loss-of-signal.
module bk_pulse_monitor #(
    parameter int unsigned WIDTH_MIN  = 800,
    parameter int unsigned WIDTH_MAX  = 950,
    parameter int unsigned PERIOD_MIN = 490000,
    parameter int unsigned PERIOD_MAX = 510000,
    parameter int unsigned TIMEOUT    = 1250000,
    parameter int unsigned GOOD_CNT   = 3
) (
    input  logic        i_clk_25m,
    input  logic        i_rst,
    input  logic        i_bk_pulse,
    input  logic        i_clr,
    output logic [20:0] o_width,
    output logic [20:0] o_period,
    output logic        o_meas_valid,
    output logic        o_pulse_ok,
    output logic        o_fault,
    output logic        o_loss
);

    localparam int unsigned CNT_W  = 21;
    localparam int unsigned GOOD_W = $clog2(GOOD_CNT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               sync_ff;
    logic               s;
    logic               s_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   width_q;
    logic [GOOD_W-1:0]  good_cnt;

    logic               rise_c;
    logic               fall_c;
    logic               at_timeout_c;
    logic               arm_c;
    logic               latch_w_c;
    logic               meas_c;
    logic               loss_c;
    logic               good_c;
    logic [GOOD_W-1:0]  good_inc_c;

    // Two-flop synchronizer plus edge-detect delay stage
    always_ff @(posedge i_clk_25m) begin
        if (i_rst) begin
            sync_ff <= 1'b0;
            s       <= 1'b0;
            s_d     <= 1'b0;
        end else begin
            sync_ff <= i_bk_pulse;
            s       <= sync_ff;
            s_d     <= s;
        end
    end

    assign rise_c       = s & ~s_d;
    assign fall_c       = ~s & s_d;
    assign at_timeout_c = (cnt == CNT_W'(TIMEOUT));

    // Restarts at 1 on every rise so it reads width at fall and period at next rise
    always_ff @(posedge i_clk_25m) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (rise_c) begin
            cnt <= CNT_W'(1);
        end else if (!at_timeout_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk_25m) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        arm_c     = 1'b0;
        latch_w_c = 1'b0;
        meas_c    = 1'b0;
        loss_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    state_d = HIGH;
                    arm_c   = 1'b1;
                end
            end
            HIGH: begin
                if (at_timeout_c) begin
                    state_d = IDLE;
                    loss_c  = 1'b1;
                end else if (fall_c) begin
                    state_d   = LOW;
                    latch_w_c = 1'b1;
                end
            end
            LOW: begin
                if (at_timeout_c) begin
                    state_d = IDLE;
                    loss_c  = 1'b1;
                end else if (rise_c) begin
                    state_d = HIGH;
                    meas_c  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign good_c = (width_q >= CNT_W'(WIDTH_MIN))  && (width_q <= CNT_W'(WIDTH_MAX)) &&
                    (cnt     >= CNT_W'(PERIOD_MIN)) && (cnt     <= CNT_W'(PERIOD_MAX));

    assign good_inc_c = (good_cnt == GOOD_W'(GOOD_CNT)) ? good_cnt : good_cnt + GOOD_W'(1);

    // Registered measurement, qualification and status outputs
    always_ff @(posedge i_clk_25m) begin
        if (i_rst) begin
            width_q      <= '0;
            good_cnt     <= '0;
            o_width      <= '0;
            o_period     <= '0;
            o_meas_valid <= 1'b0;
            o_pulse_ok   <= 1'b0;
            o_fault      <= 1'b0;
            o_loss       <= 1'b0;
        end else begin
            o_meas_valid <= meas_c;
            if (latch_w_c) begin
                width_q <= cnt;
            end
            if (arm_c) begin
                o_loss <= 1'b0;
            end
            if (loss_c) begin
                o_loss     <= 1'b1;
                good_cnt   <= '0;
                o_pulse_ok <= 1'b0;
            end
            if (meas_c) begin
                o_width  <= width_q;
                o_period <= cnt;
                if (good_c) begin
                    good_cnt   <= good_inc_c;
                    o_pulse_ok <= (good_inc_c == GOOD_W'(GOOD_CNT));
                end else begin
                    good_cnt   <= '0;
                    o_pulse_ok <= 1'b0;
                end
            end
            // A bad measurement wins over a simultaneous clear
            if (meas_c && !good_c) begin
                o_fault <= 1'b1;
            end else if (i_clr) begin
                o_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bk_pulse_monitor.sv
// Directed bench for bk_pulse_monitor with scaled limits; expected measurements
// are queued at each input rise and checked when o_meas_valid strobes.
`timescale 1ns/1ps
module tb_bk_pulse_monitor;

    localparam int WMIN = 8;
    localparam int WMAX = 12;
    localparam int PMIN = 40;
    localparam int PMAX = 50;
    localparam int TMO  = 100;
    localparam int GOOD = 3;

    typedef struct packed {
        logic [20:0] w;
        logic [20:0] p;
        logic        ok;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        bk;
    logic        clr;
    logic [20:0] o_width;
    logic [20:0] o_period;
    logic        o_meas_valid;
    logic        o_pulse_ok;
    logic        o_fault;
    logic        o_loss;

    int   total = 0;
    int   bad   = 0;
    int   n_push = 0;
    int   n_seen = 0;
    exp_t sb[$];

    // bench model state
    int   g_m = 0;
    bit   fault_m = 1'b0;
    bit   have_prev = 1'b0;
    int   prev_w = 0;
    int   prev_p = 0;

    bk_pulse_monitor #(
        .WIDTH_MIN (WMIN),
        .WIDTH_MAX (WMAX),
        .PERIOD_MIN(PMIN),
        .PERIOD_MAX(PMAX),
        .TIMEOUT   (TMO),
        .GOOD_CNT  (GOOD)
    ) dut (
        .i_clk_25m   (clk),
        .i_rst       (rst),
        .i_bk_pulse  (bk),
        .i_clr       (clr),
        .o_width     (o_width),
        .o_period    (o_period),
        .o_meas_valid(o_meas_valid),
        .o_pulse_ok  (o_pulse_ok),
        .o_fault     (o_fault),
        .o_loss      (o_loss)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outcome of measuring a pulse of width w and period p
    task automatic model_meas(input int w, input int p, input bit clr_on);
        exp_t e;
        bit   good;
        good = (w >= WMIN) && (w <= WMAX) && (p >= PMIN) && (p <= PMAX);
        if (good) begin
            g_m = (g_m == GOOD) ? GOOD : g_m + 1;
            if (clr_on) fault_m = 1'b0;
        end else begin
            g_m     = 0;
            fault_m = 1'b1;
        end
        e.w     = 21'(w);
        e.p     = 21'(p);
        e.ok    = (g_m == GOOD);
        e.fault = fault_m;
        sb.push_back(e);
        n_push++;
    endtask

    // One pulse: high w cycles, rise-to-rise p cycles; clr_on pulses i_clr
    // so it lands on the DUT's measurement edge for the previous pulse.
    task automatic pulse(input int w, input int p, input bit clr_on);
        if (have_prev) model_meas(prev_w, prev_p, clr_on);
        else if (clr_on) fault_m = 1'b0;
        bk = 1'b1;
        for (int k = 1; k <= p; k++) begin
            @(negedge clk);
            if (k == w) bk = 1'b0;
            if (clr_on && k == 2) clr = 1'b1;
            if (k == 3) clr = 1'b0;
        end
        have_prev = 1'b1;
        prev_w    = w;
        prev_p    = p;
    endtask

    // Rise then silence (w>0: drop low after w cycles, w==0: stuck high)
    task automatic rise_to_loss(input int w, input string tag);
        if (have_prev) model_meas(prev_w, prev_p, 1'b0);
        bk = 1'b1;
        for (int k = 1; k <= TMO + 3; k++) begin
            @(negedge clk);
            if (k == w) bk = 1'b0;
            if (k == TMO + 2) chk({tag, "_loss_early"}, 32'(o_loss), 32'd0);
            if (k == TMO + 3) begin
                chk({tag, "_loss_set"}, 32'(o_loss), 32'd1);
                chk({tag, "_ok_drop"}, 32'(o_pulse_ok), 32'd0);
            end
        end
        have_prev = 1'b0;
        g_m       = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_width"},  32'(o_width), 32'd0);
        chk({tag, "_period"}, 32'(o_period), 32'd0);
        chk({tag, "_valid"},  32'(o_meas_valid), 32'd0);
        chk({tag, "_ok"},     32'(o_pulse_ok), 32'd0);
        chk({tag, "_fault"},  32'(o_fault), 32'd0);
        chk({tag, "_loss"},   32'(o_loss), 32'd0);
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (o_meas_valid) begin
            exp_t e;
            n_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_meas", 32'(o_width), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("meas_width",  32'(o_width), 32'(e.w));
                chk("meas_period", 32'(o_period), 32'(e.p));
                chk("meas_ok",     32'(o_pulse_ok), 32'(e.ok));
                chk("meas_fault",  32'(o_fault), 32'(e.fault));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bk  = 1'b0;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        // Nominal lock, then a short width fault and recovery
        for (int i = 0; i < 5; i++) pulse(10, 45, 1'b0);
        pulse(7, 45, 1'b0);
        for (int i = 0; i < 4; i++) pulse(10, 45, 1'b0);
        pulse(10, 45, 1'b1);

        // Inclusive limits, then out-of-range period and width
        pulse(8, 40, 1'b0);
        pulse(12, 50, 1'b0);
        pulse(8, 50, 1'b0);
        pulse(12, 40, 1'b0);
        pulse(10, 45, 1'b0);
        pulse(10, 51, 1'b0);
        pulse(10, 45, 1'b1);
        pulse(7, 45, 1'b0);
        pulse(10, 45, 1'b1);
        pulse(10, 45, 1'b1);
        for (int i = 0; i < 3; i++) pulse(10, 45, 1'b0);

        // Loss while low, re-arm without measurement, then stuck high
        rise_to_loss(10, "low");
        chk("fault_kept_on_loss", 32'(o_fault), 32'(fault_m));
        pulse(10, 45, 1'b0);
        chk("loss_cleared", 32'(o_loss), 32'd0);
        pulse(10, 45, 1'b0);
        rise_to_loss(0, "high");

        // Reset during the high phase
        rst = 1'b1;
        repeat (2) @(negedge clk);
        bk = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        g_m       = 0;
        fault_m   = 1'b0;
        have_prev = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        n_push = 0;
        n_seen = 0;
        for (int i = 0; i < 3; i++) pulse(10, 45, 1'b0);
        repeat (10) @(negedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("meas_count", 32'(n_seen), 32'(n_push));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
